// File: rtl/sh7604_ext_bus_target.sv
// Slave side of SH7604 normal-space bus cycles: turns each CPU cycle into one backend
// request, stretches it with WAIT_N, and answers interrupt-vector fetches.
module sh7604_ext_bus_target #(
   parameter logic [1:0] BUS_SZ = 2'b11,
   parameter logic       VEC_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic [26:0] A,
   input  logic [31:0] BUS_DI,
   output logic [31:0] BUS_DO,
   input  logic        BS_N,
   input  logic        CS_N,
   input  logic        RD_WR_N,
   input  logic        RD_N,
   input  logic [3:0]  WE_N,
   input  logic        IVECF_N,
   output logic        WAIT_N,
   output logic [24:0] MEM_A,
   output logic [31:0] MEM_WDATA,
   output logic [3:0]  MEM_BE,
   output logic        MEM_WE,
   output logic        MEM_REQ,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK,
   input  logic [7:0]  VEC_IN,
   output logic        VEC_ACK
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_VEC    = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] bus_do_q, bus_do_d;
   logic        wait_n_q, wait_n_d;
   logic [24:0] mem_a_q, mem_a_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_req_q, mem_req_d;
   logic        vec_ack_q, vec_ack_d;
   logic [1:0]  lane_a_q, lane_a_d;

   logic vec_start_s;
   logic acc_start_s;
   logic no_lane_s;
   logic unused_addr_s;

   // Active-high byte-enable mask; lane 3 carries the lowest byte address (big-endian).
   function automatic logic [3:0] lane_be(input logic [1:0] a, input logic rd,
                                          input logic [3:0] we_n);
      logic [3:0] be;
      case (BUS_SZ)
         2'b01: begin
            if (rd || !we_n[0]) be = 4'b1000 >> a;
            else                be = 4'b0000;
         end
         2'b10: begin
            if (rd)        be = a[1] ? 4'b0011 : 4'b1100;
            else if (a[1]) be = {2'b00, ~we_n[1:0]};
            else           be = {~we_n[1:0], 2'b00};
         end
         default: be = rd ? 4'b1111 : ~we_n;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] wr_lanes(input logic [1:0] a, input logic [31:0] di);
      logic [31:0] wd;
      case (BUS_SZ)
         2'b01:   wd = {4{di[7:0]}};
         2'b10:   wd = a[1] ? {16'h0000, di[15:0]} : {di[15:0], 16'h0000};
         default: wd = di;
      endcase
      return wd;
   endfunction

   function automatic logic [31:0] rd_justify(input logic [1:0] a, input logic [31:0] rd);
      logic [31:0] dout;
      case (BUS_SZ)
         2'b01: begin
            case (a)
               2'b00:   dout = {24'h000000, rd[31:24]};
               2'b01:   dout = {24'h000000, rd[23:16]};
               2'b10:   dout = {24'h000000, rd[15:8]};
               default: dout = {24'h000000, rd[7:0]};
            endcase
         end
         2'b10:   dout = a[1] ? {16'h0000, rd[15:0]} : {16'h0000, rd[31:16]};
         default: dout = rd;
      endcase
      return dout;
   endfunction

   assign unused_addr_s = ^A[26:25];

   // When VEC_EN=0 IVECF_N is treated as permanently inactive.
   assign vec_start_s = VEC_EN & ~BS_N & ~IVECF_N & ~RD_N;
   assign acc_start_s = ~BS_N & ~CS_N & (IVECF_N | ~VEC_EN);
   assign no_lane_s   = ~RD_WR_N & (WE_N == 4'b1111);

   // Next-state and output-register computation.
   always_comb begin
      state_d     = state_q;
      bus_do_d    = bus_do_q;
      mem_a_d     = mem_a_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      mem_we_d    = mem_we_q;
      mem_req_d   = mem_req_q;
      lane_a_d    = lane_a_q;
      vec_ack_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (CE_R && vec_start_s) begin
               state_d   = ST_VEC;
               bus_do_d  = {24'h000000, VEC_IN};
               vec_ack_d = 1'b1;
            end else if (CE_R && acc_start_s && no_lane_s) begin
               state_d = ST_DONE;
            end else if (CE_R && acc_start_s) begin
               state_d     = ST_ACCESS;
               mem_req_d   = 1'b1;
               mem_a_d     = {A[24:2], 2'b00};
               mem_we_d    = ~RD_WR_N;
               mem_be_d    = lane_be(A[1:0], RD_WR_N, WE_N);
               mem_wdata_d = wr_lanes(A[1:0], BUS_DI);
               lane_a_d    = A[1:0];
            end else if (CE_R && CS_N && (state_q == ST_DONE)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_ACCESS: begin
            if (MEM_ACK) begin
               state_d   = ST_DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) bus_do_d = rd_justify(lane_a_q, MEM_RDATA);
               else           bus_do_d = bus_do_q;
            end else begin
               state_d   = ST_ACCESS;
               mem_req_d = 1'b1;
            end
         end
         ST_VEC: begin
            if (CE_R && IVECF_N) state_d = ST_IDLE;
            else                 state_d = ST_VEC;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
      // Looking at the next state lets an ack landing on the CE_F edge still release the CPU.
      if (CE_F) wait_n_d = (state_d != ST_ACCESS);
      else      wait_n_d = wait_n_q;
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         bus_do_q    <= 32'h00000000;
         wait_n_q    <= 1'b1;
         mem_a_q     <= 25'h0000000;
         mem_wdata_q <= 32'h00000000;
         mem_be_q    <= 4'b0000;
         mem_we_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         vec_ack_q   <= 1'b0;
         lane_a_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         bus_do_q    <= bus_do_d;
         wait_n_q    <= wait_n_d;
         mem_a_q     <= mem_a_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_we_q    <= mem_we_d;
         mem_req_q   <= mem_req_d;
         vec_ack_q   <= vec_ack_d;
         lane_a_q    <= lane_a_d;
      end
   end

   assign BUS_DO    = bus_do_q;
   assign WAIT_N    = wait_n_q;
   assign MEM_A     = mem_a_q;
   assign MEM_WDATA = mem_wdata_q;
   assign MEM_BE    = mem_be_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_REQ   = mem_req_q;
   assign VEC_ACK   = vec_ack_q;

endmodule

// File: tb/tb_sh7604_ext_bus_target.sv
// Bench for sh7604_ext_bus_target: 32/16/8-bit instances share one CPU bus, each with its
// own chip select and byte-array backend; a big-endian byte model gives expected read data.
module tb_sh7604_ext_bus_target;

   logic        CLK = 1'b0;
   logic        RST_N, CE_R, CE_F;
   logic [26:0] A;
   logic [31:0] BUS_DI;
   logic        BS_N, RD_WR_N, RD_N, IVECF_N;
   logic [3:0]  WE_N;
   logic [7:0]  VEC_IN;
   logic        cs_n   [3];
   logic [31:0] bus_do [3];
   logic        wait_n [3];
   logic [24:0] mem_a  [3];
   logic [31:0] wdata  [3];
   logic [3:0]  be     [3];
   logic        we     [3];
   logic        req    [3];
   logic [31:0] rdata  [3];
   logic        ack    [3];
   logic        vack   [3];

   int checks = 0;
   int errors = 0;
   int phase;
   logic [7:0]  bmem [3][256];
   logic [7:0]  refm [3][256];
   int          req_cnt [3];
   int          vack_cnt[3];
   logic        req_prev[3];
   int          dly     [3];
   bit          busy    [3];
   bit          auto_ack;
   int          ack_delay;
   logic [24:0] cap_a   [3];
   logic [3:0]  cap_be  [3];
   logic        cap_we  [3];
   logic [31:0] cap_wd  [3];

   sh7604_ext_bus_target #(.BUS_SZ(2'b11), .VEC_EN(1'b1)) u32 (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .BUS_DI(BUS_DI),
      .BUS_DO(bus_do[0]), .BS_N(BS_N), .CS_N(cs_n[0]), .RD_WR_N(RD_WR_N), .RD_N(RD_N),
      .WE_N(WE_N), .IVECF_N(IVECF_N), .WAIT_N(wait_n[0]), .MEM_A(mem_a[0]),
      .MEM_WDATA(wdata[0]), .MEM_BE(be[0]), .MEM_WE(we[0]), .MEM_REQ(req[0]),
      .MEM_RDATA(rdata[0]), .MEM_ACK(ack[0]), .VEC_IN(VEC_IN), .VEC_ACK(vack[0]));

   sh7604_ext_bus_target #(.BUS_SZ(2'b10), .VEC_EN(1'b1)) u16 (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .BUS_DI(BUS_DI),
      .BUS_DO(bus_do[1]), .BS_N(BS_N), .CS_N(cs_n[1]), .RD_WR_N(RD_WR_N), .RD_N(RD_N),
      .WE_N(WE_N), .IVECF_N(IVECF_N), .WAIT_N(wait_n[1]), .MEM_A(mem_a[1]),
      .MEM_WDATA(wdata[1]), .MEM_BE(be[1]), .MEM_WE(we[1]), .MEM_REQ(req[1]),
      .MEM_RDATA(rdata[1]), .MEM_ACK(ack[1]), .VEC_IN(VEC_IN), .VEC_ACK(vack[1]));

   sh7604_ext_bus_target #(.BUS_SZ(2'b01), .VEC_EN(1'b1)) u8 (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .BUS_DI(BUS_DI),
      .BUS_DO(bus_do[2]), .BS_N(BS_N), .CS_N(cs_n[2]), .RD_WR_N(RD_WR_N), .RD_N(RD_N),
      .WE_N(WE_N), .IVECF_N(IVECF_N), .WAIT_N(wait_n[2]), .MEM_A(mem_a[2]),
      .MEM_WDATA(wdata[2]), .MEM_BE(be[2]), .MEM_WE(we[2]), .MEM_REQ(req[2]),
      .MEM_RDATA(rdata[2]), .MEM_ACK(ack[2]), .VEC_IN(VEC_IN), .VEC_ACK(vack[2]));

   initial forever #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Ack sampled at edge d+1 after the start edge; CE_F edges fall at 2, 6, 10, ...
   function automatic int exp_waits(input int d);
      int w = 0;
      for (int e = 2; e < d + 1; e += 4) w++;
      return w;
   endfunction

   task automatic backend_op(input int k);
      logic [7:0] ba;
      ba = mem_a[k][7:0];
      if (we[k]) begin
         for (int l = 0; l < 4; l++)
            if (be[k][l]) bmem[k][ba + 8'(3 - l)] = wdata[k][8*l +: 8];
      end else begin
         rdata[k] = {bmem[k][ba], bmem[k][ba + 8'd1], bmem[k][ba + 8'd2], bmem[k][ba + 8'd3]};
      end
   endtask

   // One CLK: observe outputs, run the backends, then set the CE flags for the next edge.
   task automatic tick();
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
         if (req[k] && !req_prev[k]) begin
            req_cnt[k]++;
            cap_a[k] = mem_a[k]; cap_be[k] = be[k]; cap_we[k] = we[k]; cap_wd[k] = wdata[k];
         end
         req_prev[k] = req[k];
         if (vack[k]) vack_cnt[k]++;
      end
      for (int k = 0; k < 3; k++) begin
         if (ack[k]) begin
            ack[k] = 1'b0; busy[k] = 1'b0;
         end else if (req[k] && auto_ack) begin
            if (!busy[k]) begin busy[k] = 1'b1; dly[k] = ack_delay; end
            if (dly[k] == 0) begin backend_op(k); ack[k] = 1'b1; end
            else dly[k]--;
         end
      end
      phase = (phase + 1) % 4;
      CE_R  = (phase == 0);
      CE_F  = (phase == 2);
   endtask

   task automatic to_ce_r();
      while (!CE_R) tick();
   endtask

   // CPU side of one normal-space cycle.
   task automatic cpu_access(input int k, input logic [26:0] addr, input logic rd,
                             input logic [3:0] wen, input logic [31:0] di, input bit keep,
                             output bit done, output int waits,
                             output logic [31:0] pre, output logic [31:0] post);
      int guard;
      to_ce_r();
      A = addr; BS_N = 1'b0; cs_n[k] = 1'b0; RD_WR_N = rd; RD_N = !rd;
      WE_N = rd ? 4'hF : wen; BUS_DI = di;
      tick();
      BS_N = 1'b1;
      done = 1'b0; waits = 0; guard = 0;
      while (!done && guard < 400) begin
         tick(); guard++;
         if (CE_R) begin
            if (wait_n[k]) done = 1'b1;
            else waits++;
         end
      end
      while (!CE_F) tick();
      pre = bus_do[k];
      tick();
      post = bus_do[k];
      RD_N = 1'b1; WE_N = 4'hF;
      if (!keep) cs_n[k] = 1'b1;
   endtask

   task automatic do_op(input int k, input logic [26:0] addr, input logic rd,
                        input logic [3:0] wen, input logic [31:0] di, input bit keep);
      int nb, rc, waits, ew;
      bit done, exp_req;
      logic exp_we;
      logic [31:0] pre, post, exp_rd;
      logic [7:0] a;
      nb = (k == 0) ? 4 : (k == 1) ? 2 : 1;
      a = addr[7:0];
      exp_req = rd || (wen != 4'hF);
      exp_we = !rd;
      ew = exp_req ? exp_waits(ack_delay) : 0;
      exp_rd = 32'h0;
      for (int i = 0; i < nb; i++) exp_rd = (exp_rd << 8) | 32'(refm[k][a + 8'(i)]);
      rc = req_cnt[k];
      cpu_access(k, addr, rd, wen, di, keep, done, waits, pre, post);
      check("cycle_done", 32'(done), 32'd1);
      check("req_count", req_cnt[k] - rc, 32'(exp_req));
      check("wait_states", waits, ew);
      if (exp_req) begin
         check("mem_a", 32'(cap_a[k]), 32'({addr[24:2], 2'b00}));
         check("mem_we", 32'(cap_we[k]), 32'(exp_we));
      end
      if (rd) begin
         check("rd_t2", pre, exp_rd);
         check("rd_hold", post, exp_rd);
      end else begin
         for (int i = 0; i < nb; i++)
            if (!wen[nb - 1 - i]) refm[k][a + 8'(i)] = di[8*(nb - 1 - i) +: 8];
      end
   endtask

   task automatic vec_fetch(input logic [7:0] v, input bit cs0_low);
      int vc[3], rc[3];
      for (int k = 0; k < 3; k++) begin vc[k] = vack_cnt[k]; rc[k] = req_cnt[k]; end
      to_ce_r();
      BS_N = 1'b0; IVECF_N = 1'b0; RD_N = 1'b0; RD_WR_N = 1'b1; VEC_IN = v;
      if (cs0_low) cs_n[0] = 1'b0;
      tick();
      BS_N = 1'b1;
      to_ce_r();
      for (int k = 0; k < 3; k++) check("vec_wait_n", 32'(wait_n[k]), 32'd1);
      while (!CE_F) tick();
      for (int k = 0; k < 3; k++) check("vec_bus_do", bus_do[k], {24'h000000, v});
      tick();
      IVECF_N = 1'b1; RD_N = 1'b1; cs_n[0] = 1'b1;
      to_ce_r();
      tick();
      for (int k = 0; k < 3; k++) begin
         check("vec_ack_pulses", vack_cnt[k] - vc[k], 32'd1);
         check("vec_no_req", req_cnt[k] - rc[k], 32'd0);
      end
   endtask

   initial begin
      logic [26:0] ad;
      logic [31:0] d;
      int k, rc0, vc0, mism;
      RST_N = 1'b0; CE_R = 1'b0; CE_F = 1'b0; phase = 3;
      A = 27'h0; BUS_DI = 32'h0; BS_N = 1'b1; RD_WR_N = 1'b1; RD_N = 1'b1;
      WE_N = 4'hF; IVECF_N = 1'b1; VEC_IN = 8'h00; auto_ack = 1'b1; ack_delay = 0;
      for (int j = 0; j < 3; j++) begin
         cs_n[j] = 1'b1; ack[j] = 1'b0; rdata[j] = 32'h0; req_cnt[j] = 0; vack_cnt[j] = 0;
         req_prev[j] = 1'b0; busy[j] = 1'b0; dly[j] = 0;
         for (int b = 0; b < 256; b++) begin
            bmem[j][b] = 8'($urandom); refm[j][b] = bmem[j][b];
         end
      end
      repeat (3) @(negedge CLK);
      for (int j = 0; j < 3; j++) begin
         check("rst_bus_do", bus_do[j], 32'h0);
         check("rst_ctl", {27'h0, wait_n[j], req[j], we[j], vack[j], 1'b0}, {27'h0, 5'b10000});
         check("rst_mem_be", 32'(be[j]), 32'h0);
         check("rst_mem_a", 32'(mem_a[j]), 32'h0);
         check("rst_wdata", wdata[j], 32'h0);
      end
      RST_N = 1'b1;
      repeat (4) tick();

      // 32-bit write, ack 3 CLK after request
      ack_delay = 3;
      do_op(0, 27'h0000100, 1'b0, 4'b0000, 32'hDEADBEEF, 1'b0);
      check("w32_be", 32'(cap_be[0]), 32'h0000000F);
      check("w32_wdata", cap_wd[0], 32'hDEADBEEF);

      // 16-bit read from the low half
      ack_delay = 2;
      bmem[1][8'h40] = 8'h12; bmem[1][8'h41] = 8'h34; bmem[1][8'h42] = 8'h56; bmem[1][8'h43] = 8'h78;
      refm[1][8'h40] = 8'h12; refm[1][8'h41] = 8'h34; refm[1][8'h42] = 8'h56; refm[1][8'h43] = 8'h78;
      do_op(1, 27'h0000042, 1'b1, 4'hF, 32'h0, 1'b0);
      check("r16_be", 32'(cap_be[1]), 32'h00000003);

      // 8-bit back-to-back sub-accesses with CS_N held low
      ack_delay = 1;
      for (int i = 0; i < 4; i++) begin
         d = 32'hAA + 32'(i) * 32'h11;
         do_op(2, 27'h0000080 + 27'(i), 1'b0, 4'b1110, d, i < 3);
         check("b2b_be", 32'(cap_be[2]), 32'h8 >> i);
         check("b2b_wdata", cap_wd[2], {4{d[7:0]}});
      end

      // zero-wait cycles: ack in the first CLK of MEM_REQ, or one CLK later
      ack_delay = 0;
      do_op(0, 27'h0000100, 1'b1, 4'hF, 32'h0, 1'b0);
      ack_delay = 1;
      do_op(2, 27'h0000082, 1'b1, 4'hF, 32'h0, 1'b0);

      // write with no lanes strobed needs no backend request
      do_op(0, 27'h0000010, 1'b0, 4'hF, 32'h11223344, 1'b0);

      vec_fetch(8'h47, 1'b0);
      vec_fetch(8'($urandom), 1'b1);

      // BS_N with no chip select and no vector fetch is ignored
      rc0 = req_cnt[0] + req_cnt[1] + req_cnt[2];
      vc0 = vack_cnt[0] + vack_cnt[1] + vack_cnt[2];
      to_ce_r();
      BS_N = 1'b0;
      tick();
      BS_N = 1'b1;
      repeat (8) tick();
      check("stray_bs_req", req_cnt[0] + req_cnt[1] + req_cnt[2] - rc0, 32'd0);
      check("stray_bs_vack", vack_cnt[0] + vack_cnt[1] + vack_cnt[2] - vc0, 32'd0);

      for (int it = 0; it < 60; it++) begin
         k = $urandom_range(0, 2);
         ad = 27'($urandom);
         if (k == 0) ad[1:0] = 2'b00;
         if (k == 1) ad[0] = 1'b0;
         ack_delay = $urandom_range(0, 3);
         do_op(k, ad, 1'($urandom), 4'($urandom), $urandom, 1'b0);
      end

      for (int j = 0; j < 3; j++) begin
         mism = 0;
         for (int b = 0; b < 256; b++) if (bmem[j][b] !== refm[j][b]) mism++;
         check("mem_image", mism, 32'd0);
      end

      // asynchronous reset in the middle of an access
      auto_ack = 1'b0;
      to_ce_r();
      A = 27'h0000200; cs_n[0] = 1'b0; BS_N = 1'b0; RD_WR_N = 1'b1; RD_N = 1'b0; WE_N = 4'hF;
      tick();
      BS_N = 1'b1;
      repeat (6) tick();
      check("pre_rst_req", 32'(req[0]), 32'd1);
      check("pre_rst_wait_n", 32'(wait_n[0]), 32'd0);
      #1 RST_N = 1'b0;
      #1;
      check("rst_req_drop", 32'(req[0]), 32'd0);
      check("rst_wait_n", 32'(wait_n[0]), 32'd1);
      tick();
      cs_n[0] = 1'b1; RD_N = 1'b1; RST_N = 1'b1;
      tick();
      rc0 = req_cnt[0];
      ack[0] = 1'b1;
      rdata[0] = 32'hCAFEF00D;
      repeat (8) tick();
      check("late_ack_req", 32'(req[0]), 32'd0);
      check("late_ack_wait_n", 32'(wait_n[0]), 32'd1);
      check("late_ack_bus_do", bus_do[0], 32'h0);
      check("late_ack_req_cnt", req_cnt[0] - rc0, 32'd0);
      for (int j = 0; j < 3; j++) busy[j] = 1'b0;
      auto_ack = 1'b1;
      ack_delay = 2;
      do_op(0, 27'h0000100, 1'b1, 4'hF, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
